dram_burst_mem: RTL

DRAM_BURST_MEM -- requirements
Module: dram_burst_mem

---
 rtl/dram_burst_mem.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dram_burst_mem.sv
// dram_burst_mem -- single-port burst memory with a DRAM-like access latency.
//
// A request (req_valid/req_ready) latches a line-aligned byte address and a
// read/write flag. After LATENCY access cycles the block either streams
// LINE_WORDS read beats (rd_valid/rd_data/rd_last, no backpressure) or
// accepts LINE_WORDS write beats (wr_valid/wr_ready/wr_data/wr_strb).
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/ready/write   burst request handshake and direction
//   req_addr                byte address of the line start
//   wr_valid/ready/data/strb write beat handshake, data, byte enables
//   rd_valid/data/last      read beat stream
//   busy                    FSM not idle
//   err                     one-cycle pulse on a misaligned request
//
// Optional feature: define DRAM_ALIGN_CHECK_EN to reject (with an err
// pulse) requests whose address is not line-aligned. Without it err is 0
// and the low address bits are dropped.
//
// The memory array has no reset: contents survive rst_n.

module dram_burst_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 17,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_strb,
  output logic                             rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_last,
  output logic                             busy,
  output logic                             err
);

  localparam int BPW        = DATA_WIDTH / BYTE_WIDTH;
  localparam int LINE_BYTES = LINE_WORDS * BPW;
  localparam int BOFF_W     = $clog2(BPW);
  localparam int WADDR_W    = ADDR_WIDTH - BOFF_W;
  localparam int NWORDS     = 2 ** WADDR_W;
  localparam int BEAT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LAT_W      = $clog2(LATENCY + 1);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, LAT, RD_BURST, WR_BURST} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic                    write_q;
  logic [LAT_W-1:0]        lat_q;
  logic [BEAT_W-1:0]       beat_q;
  logic                    req_ready_q, wr_ready_q, rd_valid_q, rd_last_q;
  logic                    busy_q, err_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;

  logic [DATA_WIDTH-1:0]   mem [0:NWORDS-1];

  // Word index of the current beat; the add wraps modulo the array size.
  logic [WADDR_W-1:0]      widx_d;
  logic                    misalign_d;
  logic                    mem_we_d;

  assign widx_d   = WADDR_W'(base_q >> BOFF_W) + WADDR_W'(beat_q);
  // wr_ready is only ever high in WR_BURST, so this is the beat handshake.
  assign mem_we_d = wr_ready_q && wr_valid;

`ifdef DRAM_ALIGN_CHECK_EN
  assign misalign_d = |(req_addr & LINE_MASK);
`else
  assign misalign_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      write_q     <= 1'b0;
      lat_q       <= '0;
      beat_q      <= '0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            if (misalign_d) begin
              // Swallow the request: one err cycle, no array access.
              err_q       <= 1'b1;
              req_ready_q <= 1'b0;
            end else begin
              base_q      <= req_addr & ~LINE_MASK;
              write_q     <= req_write;
              lat_q       <= LAT_W'(LATENCY);
              beat_q      <= '0;
              state_q     <= LAT;
              req_ready_q <= 1'b0;
              busy_q      <= 1'b1;
            end
          end
        end
        LAT: begin
          if (lat_q == LAT_W'(1)) begin
            if (write_q) begin
              state_q    <= WR_BURST;
              wr_ready_q <= 1'b1;
            end else begin
              // Beat 0 is fetched on the last LAT edge so it is visible
              // LATENCY+1 cycles after the handshake.
              state_q    <= RD_BURST;
              rd_valid_q <= 1'b1;
              rd_data_q  <= mem[widx_d];
              rd_last_q  <= (beat_q == LAST_BEAT);
              beat_q     <= beat_q + BEAT_W'(1);
            end
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        RD_BURST: begin
          if (rd_last_q) begin
            state_q     <= IDLE;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            beat_q      <= '0;
          end else begin
            rd_data_q <= mem[widx_d];
            rd_last_q <= (beat_q == LAST_BEAT);
            beat_q    <= beat_q + BEAT_W'(1);
          end
        end
        WR_BURST: begin
          if (wr_valid) begin
            if (beat_q == LAST_BEAT) begin
              state_q     <= IDLE;
              wr_ready_q  <= 1'b0;
              busy_q      <= 1'b0;
              req_ready_q <= 1'b1;
              beat_q      <= '0;
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte-masked array write; intentionally no reset.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      for (int b = 0; b < BPW; b++) begin
        if (wr_strb[b]) begin
          mem[widx_d][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
